// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller:
// FSM state encoding, credit ceiling and the default coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CALC    = 3'd2,
        VEND    = 3'd3,
        SHORT   = 3'd4
    } state_t;

    localparam int W_DEF = 4;

    // Largest credit that is still a positive value in a signed W-bit operand.
    function automatic int credit_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    localparam int CREDIT_MAX = credit_max(W_DEF);

    // Index i is the credit added by COIN[i].
    localparam logic [2:0][7:0] COIN_VAL = {8'd5, 8'd2, 8'd1};

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Button inputs and display-stage outputs of the vending credit controller,
// plus the FSM state for observation. master = button/display side, slave = controller.
interface vend_credit_ctrl_if #(
    parameter int W = 4
);

    // No valid/ready pairs here: the buttons are raw asynchronous levels, and
    // ENTER/CLR are single-cycle strobes that the display stage must latch on
    // the clock edge where they are high; A/B/SUB are valid in that same cycle.
    logic [2:0]       COIN;
    logic             BUY;
    logic             CANCEL;
    logic [W-1:0]     PRICE;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             SUB;
    logic             ENTER;
    logic             CLR;
    logic [W-1:0]     CREDIT;
    logic             DISPENSE;
    logic             REJECT;
    vend_pkg::state_t state;

    modport master (
        output COIN, BUY, CANCEL, PRICE,
        input  A, B, SUB, ENTER, CLR, CREDIT, DISPENSE, REJECT, state
    );

    modport slave (
        input  COIN, BUY, CANCEL, PRICE,
        output A, B, SUB, ENTER, CLR, CREDIT, DISPENSE, REJECT, state
    );

endinterface

// File: rtl/vend_credit_ctrl_btn_edge.sv
// Raw button conditioning: 2-FF synchronizer, optional debouncer (VEND_DEBOUNCE_EN)
// and a registered rising-edge pulse, 3 clocks after the pin rises (DB_CYC+3 with debounce).
module btn_edge #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise
);

    logic [1:0] sync_q;
    logic       level;
    logic       level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

`ifdef VEND_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYC) + 1;

    logic [CW-1:0] db_cnt;
    logic          stable;

    // A new level is adopted on the DB_CYC-th consecutive differing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (sync_q[1] == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DB_CYC - 1)) begin
            stable <= sync_q[1];
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = stable;
`else
    // DB_CYC has no effect in this build; both branches pass the level straight on.
    if (DB_CYC > 0) begin : g_direct
        assign level = sync_q[1];
    end else begin : g_direct_zero
        assign level = sync_q[1];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit FSM and datapath feeding the adder/subtractor display stage.
// Button debouncing is compiled in when VEND_DEBOUNCE_EN is defined.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int COIN0_VAL = int'(COIN_VAL[0]),
    parameter int COIN1_VAL = int'(COIN_VAL[1]),
    parameter int COIN2_VAL = int'(COIN_VAL[2]),
    parameter int VEND_CYC  = 8,
    parameter int DB_CYC    = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    vend_credit_ctrl_if.slave    bus
);

    localparam int CMAX  = credit_max(W);
    localparam int VW    = W + 1;
    localparam int CNT_W = $clog2(VEND_CYC + 1);

    logic [4:0] raw;
    logic [4:0] edges;

    assign raw = {bus.CANCEL, bus.BUY, bus.COIN};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_edge #(.DB_CYC(DB_CYC)) u_btn (
            .clk  (clk),
            .rst  (RST),
            .pin  (raw[i]),
            .rise (edges[i])
        );
    end

    logic coin_e2, coin_e1, coin_e0, buy_e, cancel_e;
    assign {cancel_e, buy_e, coin_e2, coin_e1, coin_e0} = edges;

    state_t          state, state_n;
    logic [W-1:0]    credit, credit_n;
    logic [W-1:0]    price_q, price_n;
    logic            enter_q, enter_n;
    logic            clr_q, clr_n;
    logic            reject_q, reject_n;
    logic [CNT_W-1:0] vcnt, vcnt_n;

    logic            coin_hit;
    logic [VW-1:0]   coin_val;
    logic [VW-1:0]   coin_sum;
    logic            coin_ok;

    // Highest-value coin wins; lower coins in the same cycle are dropped.
    always_comb begin
        coin_hit = coin_e2 | coin_e1 | coin_e0;
        coin_val = '0;
        if (coin_e2) begin
            coin_val = VW'(COIN2_VAL);
        end else if (coin_e1) begin
            coin_val = VW'(COIN1_VAL);
        end else if (coin_e0) begin
            coin_val = VW'(COIN0_VAL);
        end
        coin_sum = {1'b0, credit} + coin_val;
        coin_ok  = (coin_sum <= VW'(CMAX));
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            credit   <= '0;
            price_q  <= '0;
            enter_q  <= 1'b0;
            clr_q    <= 1'b0;
            reject_q <= 1'b0;
            vcnt     <= '0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            price_q  <= price_n;
            enter_q  <= enter_n;
            clr_q    <= clr_n;
            reject_q <= reject_n;
            vcnt     <= vcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        price_n  = price_q;
        enter_n  = 1'b0;
        clr_n    = 1'b0;
        reject_n = 1'b0;
        vcnt_n   = vcnt;
        case (state)
            IDLE: begin
                if (coin_hit) begin
                    if (coin_ok) begin
                        credit_n = coin_sum[W-1:0];
                        enter_n  = 1'b1;
                        state_n  = COLLECT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel_e) begin
                    credit_n = '0;
                    clr_n    = 1'b1;
                    state_n  = IDLE;
                end else if (buy_e) begin
                    price_n = bus.PRICE;
                    state_n = CALC;
                end else if (coin_hit) begin
                    if (coin_ok) begin
                        credit_n = coin_sum[W-1:0];
                        enter_n  = 1'b1;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            CALC: begin
                // Change is taken out as VEND begins so the LEDs show it while dispensing.
                if (credit >= price_q) begin
                    credit_n = credit - price_q;
                    vcnt_n   = '0;
                    state_n  = VEND;
                end else begin
                    state_n = SHORT;
                end
            end
            VEND: begin
                if (vcnt == CNT_W'(VEND_CYC - 1)) begin
                    vcnt_n  = '0;
                    state_n = (credit == '0) ? IDLE : COLLECT;
                end else begin
                    vcnt_n = vcnt + 1'b1;
                end
            end
            SHORT: begin
                state_n = COLLECT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.A        = credit;
    assign bus.CREDIT   = credit;
    assign bus.B        = (state == CALC) ? price_q : '0;
    assign bus.SUB      = (state == CALC);
    assign bus.ENTER    = enter_q | (state == CALC);
    assign bus.CLR      = clr_q;
    assign bus.DISPENSE = (state == VEND);
    assign bus.REJECT   = reject_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl: hand-computed credit/strobe expectations,
// plus a scoreboard of expected A values for every ENTER strobe.
module tb_vend_credit_ctrl;
    import vend_pkg::*;

    localparam int W = 4;
`ifdef VEND_DEBOUNCE_EN
    localparam int LAT = 16 + 3;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vend_credit_ctrl_if #(.W(W)) bus ();

    vend_credit_ctrl #(.W(W)) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int dcnt;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the pins until the cycle where the resulting action is visible.
    task automatic press(input logic [2:0] coin, input logic buy, input logic cancel);
        bus.COIN   = coin;
        bus.BUY    = buy;
        bus.CANCEL = cancel;
        tick(LAT + 1);
        bus.COIN   = 3'b000;
        bus.BUY    = 1'b0;
        bus.CANCEL = 1'b0;
    endtask

    task automatic settle();
        tick(LAT + 3);
    endtask

    task automatic count_dispense(input int n);
        dcnt = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.DISPENSE) dcnt++;
            tick(1);
        end
    endtask

    // Scoreboard: every ENTER must carry the next expected credit on A.
    always @(negedge clk) begin
        if (!rst && bus.ENTER) begin
            if (exp_q.size() == 0) check("enter_unexpected", 32'(bus.ENTER), 32'd0);
            else check("enter_a", 32'(bus.A), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.COIN   = 3'b000;
        bus.BUY    = 1'b0;
        bus.CANCEL = 1'b0;
        bus.PRICE  = '0;
        tick(3);
        check("rst_outs", 32'({bus.A, bus.B, bus.SUB, bus.ENTER, bus.CLR,
                               bus.CREDIT, bus.DISPENSE, bus.REJECT}), 32'd0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        rst = 1'b0;
        tick(2);

        // First coin: latency and display strobe
        exp_q.push_back(4'd2);
        bus.COIN = 3'b010;
        tick(LAT);
        check("lat_before", 32'(bus.CREDIT), 32'd0);
        tick(1);
        bus.COIN = 3'b000;
        check("coin1_credit", 32'(bus.CREDIT), 32'd2);
        check("coin1_enter", 32'(bus.ENTER), 32'd1);
        check("coin1_sub", 32'(bus.SUB), 32'd0);
        check("coin1_b", 32'(bus.B), 32'd0);
        check("coin1_state", 32'(bus.state), 32'(COLLECT));
        tick(1);
        check("enter_one_cycle", 32'(bus.ENTER), 32'd0);
        settle();

        // Build to 5, then COIN[0] x2 to the ceiling, then a refused COIN[2]
        exp_q.push_back(4'd4); press(3'b010, 1'b0, 1'b0); check("credit_4", 32'(bus.CREDIT), 32'd4); settle();
        exp_q.push_back(4'd5); press(3'b001, 1'b0, 1'b0); check("credit_5", 32'(bus.CREDIT), 32'd5); settle();
        exp_q.push_back(4'd6); press(3'b001, 1'b0, 1'b0); check("credit_6", 32'(bus.CREDIT), 32'd6); settle();
        exp_q.push_back(4'd7); press(3'b001, 1'b0, 1'b0); check("credit_7", 32'(bus.CREDIT), 32'd7); settle();
        check("credit_max", 32'(bus.CREDIT), 32'(CREDIT_MAX));
        press(3'b100, 1'b0, 1'b0);
        check("reject_pulse", 32'(bus.REJECT), 32'd1);
        check("reject_credit", 32'(bus.CREDIT), 32'd7);
        check("reject_no_enter", 32'(bus.ENTER), 32'd0);
        tick(1);
        check("reject_one_cycle", 32'(bus.REJECT), 32'd0);
        settle();

        // Successful vend with change
        bus.PRICE = 4'd4;
        exp_q.push_back(4'd7);
        press(3'b000, 1'b1, 1'b0);
        check("calc_state", 32'(bus.state), 32'(CALC));
        check("calc_sub", 32'(bus.SUB), 32'd1);
        check("calc_b", 32'(bus.B), 32'd4);
        check("calc_enter", 32'(bus.ENTER), 32'd1);
        tick(1);
        check("vend_credit", 32'(bus.CREDIT), 32'd3);
        count_dispense(12);
        check("vend_disp_cycles", 32'(dcnt), 32'd8);
        check("vend_back_state", 32'(bus.state), 32'(COLLECT));
        settle();

        // Cancel from COLLECT, then BUY/CANCEL ignored in IDLE
        press(3'b000, 1'b0, 1'b1);
        check("cancel_clr", 32'(bus.CLR), 32'd1);
        check("cancel_credit", 32'(bus.CREDIT), 32'd0);
        check("cancel_state", 32'(bus.state), 32'(IDLE));
        tick(1);
        check("clr_one_cycle", 32'(bus.CLR), 32'd0);
        settle();
        press(3'b000, 1'b1, 1'b1);
        check("idle_ignore_state", 32'(bus.state), 32'(IDLE));
        check("idle_ignore_clr", 32'(bus.CLR), 32'd0);
        settle();

        // Short of money: credit 2, price 6
        exp_q.push_back(4'd2); press(3'b010, 1'b0, 1'b0); settle();
        bus.PRICE = 4'd6;
        exp_q.push_back(4'd2);
        press(3'b000, 1'b1, 1'b0);
        check("short_sub", 32'(bus.SUB), 32'd1);
        check("short_b", 32'(bus.B), 32'd6);
        tick(1);
        check("short_state", 32'(bus.state), 32'(SHORT));
        check("short_no_disp", 32'(bus.DISPENSE), 32'd0);
        tick(1);
        check("short_back", 32'(bus.state), 32'(COLLECT));
        check("short_credit", 32'(bus.CREDIT), 32'd2);
        settle();

        // CANCEL and BUY in the same cycle with credit 4
        exp_q.push_back(4'd4); press(3'b010, 1'b0, 1'b0); settle();
        press(3'b000, 1'b1, 1'b1);
        check("cb_clr", 32'(bus.CLR), 32'd1);
        check("cb_credit", 32'(bus.CREDIT), 32'd0);
        check("cb_state", 32'(bus.state), 32'(IDLE));
        tick(1);
        check("cb_no_calc", 32'(bus.SUB), 32'd0);
        settle();

        // Coin priority: COIN[2] and COIN[0] together count as 5 only
        exp_q.push_back(4'd5);
        press(3'b101, 1'b0, 1'b0);
        check("coin_prio", 32'(bus.CREDIT), 32'd5);
        settle();

        // PRICE=0 vends with no credit change
        bus.PRICE = 4'd0;
        exp_q.push_back(4'd5);
        press(3'b000, 1'b1, 1'b0);
        check("p0_b", 32'(bus.B), 32'd0);
        tick(1);
        count_dispense(12);
        check("p0_disp_cycles", 32'(dcnt), 32'd8);
        check("p0_credit", 32'(bus.CREDIT), 32'd5);
        settle();

        // Exact price leaves zero credit and returns to IDLE
        bus.PRICE = 4'd5;
        exp_q.push_back(4'd5);
        press(3'b000, 1'b1, 1'b0);
        tick(1);
        check("exact_credit", 32'(bus.CREDIT), 32'd0);
        count_dispense(12);
        check("exact_disp_cycles", 32'(dcnt), 32'd8);
        check("exact_state", 32'(bus.state), 32'(IDLE));
        settle();

        // Reset on the third DISPENSE cycle
        exp_q.push_back(4'd5); press(3'b100, 1'b0, 1'b0); settle();
        bus.PRICE = 4'd1;
        exp_q.push_back(4'd5);
        press(3'b000, 1'b1, 1'b0);
        tick(3);
        check("disp_before_rst", 32'(bus.DISPENSE), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outs", 32'({bus.A, bus.B, bus.SUB, bus.ENTER, bus.CLR,
                                   bus.CREDIT, bus.DISPENSE, bus.REJECT}), 32'd0);
        check("rst_mid_state", 32'(bus.state), 32'(IDLE));
        tick(2);
        rst = 1'b0;
        tick(2);

`ifdef VEND_DEBOUNCE_EN
        bus.COIN = 3'b001;
        tick(5);
        bus.COIN = 3'b000;
        tick(LAT + 10);
        check("glitch_credit", 32'(bus.CREDIT), 32'd0);
        check("glitch_state", 32'(bus.state), 32'(IDLE));
`endif

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
